bus_rx_endpoint: RTL and testbench

Receive-side responder for the shared 8-bit data bus. It snoops bus_data/bus_valid, parses framed transfers, and accepts only frames whose destination matches its own ID. Accepted payload goes into a FIFO, and the block returns a one-cycle ack or nack to the initiating data_bus. It sits between the shared bus and a crypto core (SHA/AES), which drains payload through a valid/ready port.

---
 rtl/bus_rx_endpoint_pkg.sv | 27 ++
 rtl/rx_commit_fifo.sv | 68 ++++++
 rtl/bus_rx_endpoint.sv | 151 +++++++++++++++
 tb/tb_bus_rx_endpoint.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_rx_endpoint_pkg.sv
// Shared bus definitions: header layout, node IDs and receive FSM states.
package bus_rx_endpoint_pkg;

    localparam int ID_W = 2;

    // Header byte layout: {dest_id, src_id, len}
    localparam int DEST_HI = 7;
    localparam int DEST_LO = 6;
    localparam int SRC_HI  = 5;
    localparam int SRC_LO  = 4;
    localparam int LEN_HI  = 3;
    localparam int LEN_LO  = 0;

    localparam logic [ID_W-1:0] ID_CTRL = 2'b11;
    localparam logic [ID_W-1:0] ID_SHA  = 2'b01;
    localparam logic [ID_W-1:0] ID_AES  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        SKIP,
        DROP,
        RESP_ACK,
        RESP_NACK
    } rx_state_e;

endpackage

// File: rtl/rx_commit_fifo.sv
// Payload FIFO with a staging write pointer that becomes visible only on
// commit, so a truncated frame can be discarded by rewinding.
module rx_commit_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    input  logic          commit_i,
    input  logic          rewind_i,
    input  logic          pop_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    output logic [PW-1:0] level_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] stg_q, stg_d;
    logic [PW-1:0] cmt_q, cmt_d;
    logic [PW-1:0] rd_q,  rd_d;

    assign rd_valid_o = (rd_q != cmt_q);
    assign level_o    = cmt_q - rd_q;
    // Gated so the port reads 0 whenever nothing is committed, including after reset.
    assign rd_data_o  = rd_valid_o ? mem_q[rd_q[AW-1:0]] : 8'h00;

    // Payload storage, written at the staging pointer.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[stg_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Next pointers; a commit alongside a write includes that final byte.
    always_comb begin
        stg_d = stg_q;
        cmt_d = cmt_q;
        rd_d  = rd_q;
        if (rewind_i) begin
            stg_d = cmt_q;
        end else if (wr_en_i) begin
            stg_d = stg_q + PW'(1);
        end
        if (commit_i) begin
            cmt_d = stg_d;
        end
        if (pop_i && rd_valid_o) begin
            rd_d = rd_q + PW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q <= '0;
            cmt_q <= '0;
            rd_q  <= '0;
        end else begin
            stg_q <= stg_d;
            cmt_q <= cmt_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/bus_rx_endpoint.sv
// Receive endpoint on the shared 8-bit bus: parses frames addressed to
// my_id, stages payload into a commit FIFO and answers with ack/nack.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a header byte
// RECV      | storing payload of an accepted frame
// SKIP      | counting payload of a frame for another node
// DROP      | counting payload of an own frame that did not fit
// RESP_ACK  | ack/frame_done cycle; a valid byte here is a new header
// RESP_NACK | nack cycle; a valid byte here is a new header
module bus_rx_endpoint
    import bus_rx_endpoint_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int ID_W  = bus_rx_endpoint_pkg::ID_W,
    localparam int PW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] my_id,
    input  logic [7:0]      bus_data,
    input  logic            bus_valid,
    output logic            ack,
    output logic            nack,
    output logic            out_valid,
    output logic [7:0]      out_data,
    input  logic            out_ready,
    output logic [ID_W-1:0] frame_src,
    output logic            frame_done,
    output logic            abort,
    output logic [PW-1:0]   level
);

    rx_state_e       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] src_q, src_d;
    logic [ID_W-1:0] frame_src_q, frame_src_d;
    logic            abort_q, abort_d;

    logic            wr_en, commit, rewind;
    logic [ID_W-1:0] hdr_dest, hdr_src;
    logic [3:0]      hdr_len;
    logic [PW-1:0]   free_w;
    logic            fits;

    assign hdr_dest = bus_data[DEST_HI:DEST_LO];
    assign hdr_src  = bus_data[SRC_HI:SRC_LO];
    assign hdr_len  = bus_data[LEN_HI:LEN_LO];
    // Space is judged on the level at header time; pops during the frame are not credited.
    assign free_w   = PW'(DEPTH) - level;
    assign fits     = (free_w >= PW'(hdr_len));

    rx_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (bus_data),
        .commit_i   (commit),
        .rewind_i   (rewind),
        .pop_i      (out_ready),
        .rd_data_o  (out_data),
        .rd_valid_o (out_valid),
        .level_o    (level)
    );

    assign ack        = (state_q == RESP_ACK);
    assign frame_done = (state_q == RESP_ACK);
    assign nack       = (state_q == RESP_NACK);
    assign frame_src  = frame_src_q;
    assign abort      = abort_q;

    // Next-state and FIFO control; response states also accept a header so frames can run back to back.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        frame_src_d = frame_src_q;
        abort_d     = 1'b0;
        wr_en       = 1'b0;
        commit      = 1'b0;
        rewind      = 1'b0;
        unique case (state_q)
            IDLE, RESP_ACK, RESP_NACK: begin
                state_d = IDLE;
                if (bus_valid) begin
                    cnt_d = hdr_len;
                    src_d = hdr_src;
                    if (hdr_dest != my_id) begin
                        state_d = (hdr_len == 4'd0) ? IDLE : SKIP;
                    end else if (fits) begin
                        if (hdr_len == 4'd0) begin
                            state_d     = RESP_ACK;
                            frame_src_d = hdr_src;
                        end else begin
                            state_d = RECV;
                        end
                    end else begin
                        state_d = (hdr_len == 4'd0) ? RESP_NACK : DROP;
                    end
                end
            end
            RECV: begin
                if (bus_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == 4'd1) begin
                        commit      = 1'b1;
                        frame_src_d = src_q;
                        state_d     = RESP_ACK;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    rewind  = 1'b1;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            SKIP, DROP: begin
                if (bus_valid) begin
                    if (cnt_q == 4'd1) begin
                        state_d = (state_q == DROP) ? RESP_NACK : IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and frame bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            frame_src_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            frame_src_q <= frame_src_d;
            abort_q     <= abort_d;
        end
    end

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Directed bench for bus_rx_endpoint with hand-computed expectations.
module tb_bus_rx_endpoint;

    logic       clk;
    logic       rst_n;
    logic [1:0] my_id;
    logic [7:0] bus_data;
    logic       bus_valid;
    logic       ack, nack, out_valid, frame_done, abort;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] frame_src;
    logic [4:0] level;

    int n_cmp = 0;
    int n_err = 0;

    bus_rx_endpoint #(.DEPTH(16), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .my_id      (my_id),
        .bus_data   (bus_data),
        .bus_valid  (bus_valid),
        .ack        (ack),
        .nack       (nack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_src  (frame_src),
        .frame_done (frame_done),
        .abort      (abort),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle, then settle just after the clock edge.
    task automatic tick(input logic v, input logic [7:0] d);
        bus_valid = v;
        bus_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input logic [7:0] e, input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(e));
        out_ready = 1'b1;
        tick(1'b0, 8'h00);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        my_id     = 2'b01;
        bus_data  = 8'h00;
        bus_valid = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_ack",       32'(ack),        32'd0);
        chk("rst_nack",      32'(nack),       32'd0);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_out_data",  32'(out_data),   32'd0);
        chk("rst_frame_src", 32'(frame_src),  32'd0);
        chk("rst_done",      32'(frame_done), 32'd0);
        chk("rst_abort",     32'(abort),      32'd0);
        chk("rst_level",     32'(level),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: dest 01, src 01, len 3
        tick(1'b1, 8'h53);
        tick(1'b1, 8'hA1);
        tick(1'b1, 8'hB2);
        chk("t1_no_early_ack", 32'(ack), 32'd0);
        chk("t1_hidden",       32'(out_valid), 32'd0);
        tick(1'b1, 8'hC3);
        chk("t1_ack",   32'(ack),        32'd1);
        chk("t1_done",  32'(frame_done), 32'd1);
        chk("t1_src",   32'(frame_src),  32'd1);
        chk("t1_level", 32'(level),      32'd3);
        tick(1'b0, 8'h00);
        chk("t1_ack_pulse", 32'(ack), 32'd0);
        pop(8'hA1, "t1_pop0");
        pop(8'hB2, "t1_pop1");
        pop(8'hC3, "t1_pop2");
        chk("t1_empty", 32'(out_valid), 32'd0);
        chk("t1_level0", 32'(level), 32'd0);

        // Frame for another node is skipped silently
        tick(1'b1, 8'hF2);
        tick(1'b1, 8'h01);
        chk("t2_skip_ack", 32'(ack | nack), 32'd0);
        tick(1'b1, 8'h02);
        chk("t2_skip_resp",  32'(ack | nack), 32'd0);
        chk("t2_skip_level", 32'(level),      32'd0);
        tick(1'b1, 8'h41);
        tick(1'b1, 8'h77);
        chk("t2_ack",   32'(ack),       32'd1);
        chk("t2_level", 32'(level),     32'd1);
        chk("t2_src",   32'(frame_src), 32'd0);
        tick(1'b0, 8'h00);
        pop(8'h77, "t2_pop");

        // Fill to 14, then a 3-byte frame must be refused
        tick(1'b1, 8'h4E);
        for (int i = 0; i < 14; i++) tick(1'b1, 8'(i));
        chk("t3_fill_ack",   32'(ack),   32'd1);
        chk("t3_fill_level", 32'(level), 32'd14);
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h53);
        tick(1'b1, 8'h31);
        tick(1'b1, 8'h32);
        tick(1'b1, 8'h33);
        chk("t3_nack",  32'(nack),  32'd1);
        chk("t3_noack", 32'(ack),   32'd0);
        chk("t3_level", 32'(level), 32'd14);
        tick(1'b0, 8'h00);
        chk("t3_nack_pulse", 32'(nack), 32'd0);
        // Exactly-fitting frame reaches full
        tick(1'b1, 8'h52);
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'hE1);
        chk("t3_fit_ack",  32'(ack),   32'd1);
        chk("t3_full_lvl", 32'(level), 32'd16);
        tick(1'b0, 8'h00);
        for (int i = 0; i < 14; i++) pop(8'(i), "t3_drain");
        pop(8'hE0, "t3_drain_e0");
        pop(8'hE1, "t3_drain_e1");
        chk("t3_empty", 32'(out_valid), 32'd0);
        chk("t3_level0", 32'(level), 32'd0);

        // Truncated frame is discarded and flagged
        tick(1'b1, 8'h54);
        tick(1'b1, 8'h0A);
        tick(1'b1, 8'h0B);
        chk("t4_hidden", 32'(out_valid), 32'd0);
        tick(1'b0, 8'h00);
        chk("t4_abort",  32'(abort),     32'd1);
        chk("t4_noack",  32'(ack),       32'd0);
        chk("t4_level",  32'(level),     32'd0);
        chk("t4_novalid", 32'(out_valid), 32'd0);
        tick(1'b0, 8'h00);
        chk("t4_abort_pulse", 32'(abort), 32'd0);
        chk("t4_novalid2",    32'(out_valid), 32'd0);
        tick(1'b1, 8'h51);
        tick(1'b1, 8'h99);
        chk("t4_ack",  32'(ack),      32'd1);
        chk("t4_data", 32'(out_data), 32'h99);
        tick(1'b0, 8'h00);
        pop(8'h99, "t4_pop");

        // Back-to-back frames with no idle gap
        tick(1'b1, 8'h51);
        tick(1'b1, 8'h11);
        chk("t5_ack1",  32'(ack),        32'd1);
        chk("t5_done1", 32'(frame_done), 32'd1);
        tick(1'b1, 8'h52);
        chk("t5_ack1_pulse", 32'(ack), 32'd0);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        chk("t5_ack2",  32'(ack),   32'd1);
        chk("t5_level", 32'(level), 32'd3);
        tick(1'b0, 8'h00);
        pop(8'h11, "t5_pop0");
        pop(8'h22, "t5_pop1");
        pop(8'h33, "t5_pop2");
        chk("t5_empty", 32'(out_valid), 32'd0);

        // Reset mid-frame with one byte committed and two staged
        tick(1'b1, 8'h51);
        tick(1'b1, 8'hAA);
        chk("t6_ack", 32'(ack), 32'd1);
        tick(1'b1, 8'h53);
        tick(1'b1, 8'hB1);
        tick(1'b1, 8'hB2);
        chk("t6_pre_level", 32'(level), 32'd1);
        bus_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("t6_rst_level",  32'(level),      32'd0);
        chk("t6_rst_valid",  32'(out_valid),  32'd0);
        chk("t6_rst_data",   32'(out_data),   32'd0);
        chk("t6_rst_src",    32'(frame_src),  32'd0);
        chk("t6_rst_flags",  32'({ack, nack, frame_done, abort}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b1, 8'h51);
        tick(1'b1, 8'hCC);
        chk("t6_post_ack",   32'(ack),       32'd1);
        chk("t6_post_level", 32'(level),     32'd1);
        chk("t6_post_data",  32'(out_data),  32'hCC);
        chk("t6_post_src",   32'(frame_src), 32'd1);
        tick(1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
